// File: rtl/sram_like_bridge.sv
// CPU SRAM-style port to SRAM-like req/addr_ok/data_ok bridge; stalls the pipeline per access.
// Optional SRAM_LIKE_BRIDGE_ADDR_MAP_EN: fixed kseg0/kseg1 to physical mapping at capture time.
module sram_like_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              cpu_longest_stall,
    output logic              cpu_stall,
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              addr_ok,
    input  logic              data_ok
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_req;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_wr;
    logic [1:0]        w_size;
    logic [1:0]        w_off;
    logic [ADDR_W-1:0] w_addr;

    // Returns {size, addr[1:0]}; unlisted enable patterns behave as a full word.
    function automatic logic [3:0] decode_wen(input logic [3:0] wen, input logic [1:0] a_lo);
        logic [3:0] res;
        case (wen)
            4'b0001: res = {2'd0, 2'd0};
            4'b0010: res = {2'd0, 2'd1};
            4'b0100: res = {2'd0, 2'd2};
            4'b1000: res = {2'd0, 2'd3};
            4'b0011: res = {2'd1, 2'd0};
            4'b1100: res = {2'd1, 2'd2};
            default: res = {2'd2, a_lo};
        endcase
        return res;
    endfunction

    // Request attributes as they will be captured in IDLE.
    always_comb begin
        w_wr                = |cpu_wen;
        {w_size, w_off}     = decode_wen(cpu_wen, cpu_addr[1:0]);
        w_addr              = {cpu_addr[ADDR_W-1:2], w_off};
`ifdef SRAM_LIKE_BRIDGE_ADDR_MAP_EN
        if (cpu_addr[ADDR_W-1:ADDR_W-2] == 2'b10) begin
            w_addr[ADDR_W-1:ADDR_W-3] = 3'b000;
        end else begin
            w_addr[ADDR_W-1:ADDR_W-3] = cpu_addr[ADDR_W-1:ADDR_W-3];
        end
`endif
    end

    // Transaction FSM with registered handshake outputs and read-data holding register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= {ADDR_W{1'b0}};
            r_wdata <= {DATA_W{1'b0}};
            r_rdata <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_en) begin
                        r_req   <= 1'b1;
                        r_wr    <= w_wr;
                        r_size  <= w_size;
                        r_addr  <= w_addr;
                        r_wdata <= cpu_wdata;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // data_ok without addr_ok belongs to nothing we issued yet.
                    if (addr_ok) begin
                        r_req <= 1'b0;
                        if (data_ok) begin
                            r_state <= S_DONE;
                            if (!r_wr) begin
                                r_rdata <= rdata;
                            end
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (data_ok) begin
                        r_state <= S_DONE;
                        if (!r_wr) begin
                            r_rdata <= rdata;
                        end
                    end
                end
                S_DONE: begin
                    if (!cpu_longest_stall) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Stall must be combinational so the pipeline holds in the very cycle cpu_en appears.
    assign cpu_stall = cpu_en & (r_state != S_DONE);
    assign req       = r_req;
    assign wr        = r_wr;
    assign size      = r_size;
    assign addr      = r_addr;
    assign wdata     = r_wdata;
    assign cpu_rdata = r_rdata;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Self-checking bench for sram_like_bridge: decode table, directed corner sequences, random transactions.
module tb_sram_like_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_longest_stall;
    logic        cpu_stall;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_rdata = 32'h0;

    sram_like_bridge dut (
        .clk(clk), .resetn(resetn), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_longest_stall(cpu_longest_stall), .cpu_stall(cpu_stall),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: physical address translation.
    function automatic logic [31:0] m_map(input logic [31:0] a);
`ifdef SRAM_LIKE_BRIDGE_ADDR_MAP_EN
        if (a[31:30] == 2'b10) return a & 32'h1FFF_FFFF;
        else return a;
`else
        return a;
`endif
    endfunction

    // Reference model: size / low address bits from byte enables.
    function automatic logic [3:0] m_dec(input logic [3:0] wen, input logic [1:0] a_lo);
        int n;
        n = $countones(wen);
        if (n == 1) begin
            for (int b = 0; b < 4; b++) if (wen[b]) return {2'd0, 2'(b)};
        end
        if (wen == 4'b0011 || wen == 4'b1100) return {2'd1, wen[2], 1'b0};
        return {2'd2, a_lo};
    endfunction

    // One CPU access: addr_ok after wa extra ADDR cycles, data_ok wd cycles later, then hold DONE.
    task automatic run_txn(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] es, input logic [31:0] ea,
                           input int wa, input int wdl, input logic [31:0] rd, input int hold);
        logic ew;
        ew = (wen != 4'b0000);
        @(negedge clk);
        cpu_en = 1'b1; cpu_wen = wen; cpu_addr = a; cpu_wdata = wd; cpu_longest_stall = 1'b1;
        addr_ok = 1'($urandom_range(0, 1)); data_ok = 1'($urandom_range(0, 1)); rdata = $urandom;
        #1;
        chk("idle_stall", 32'(cpu_stall), 32'd1);
        chk("idle_req", 32'(req), 32'd0);
        for (int j = 0; j <= wa; j++) begin
            @(negedge clk);
            addr_ok = (j == wa);
            data_ok = (j == wa) ? (wdl == 0) : 1'($urandom_range(0, 1));
            rdata   = (j == wa && wdl == 0) ? rd : $urandom;
            #1;
            chk("addr_req", 32'(req), 32'd1);
            chk("addr_stall", 32'(cpu_stall), 32'd1);
            chk("addr_wr", 32'(wr), 32'(ew));
            chk("addr_size", 32'(size), 32'(es));
            chk("addr_addr", addr, ea);
            chk("addr_wdata", wdata, wd);
        end
        for (int d = 1; d <= wdl; d++) begin
            @(negedge clk);
            addr_ok = 1'($urandom_range(0, 1));
            data_ok = (d == wdl);
            rdata   = (d == wdl) ? rd : $urandom;
            #1;
            chk("data_req", 32'(req), 32'd0);
            chk("data_stall", 32'(cpu_stall), 32'd1);
            chk("data_addr", addr, ea);
            chk("data_size", 32'(size), 32'(es));
        end
        if (!ew) exp_rdata = rd;
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            addr_ok = 1'($urandom_range(0, 1)); data_ok = 1'b0; rdata = $urandom;
            cpu_longest_stall = (h < hold);
            #1;
            chk("done_stall", 32'(cpu_stall), 32'd0);
            chk("done_req", 32'(req), 32'd0);
            chk("done_rdata", cpu_rdata, exp_rdata);
        end
        // IDLE gap with spurious handshakes that must be ignored
        @(negedge clk);
        cpu_en = 1'b0; cpu_longest_stall = 1'b0;
        addr_ok = 1'($urandom_range(0, 1)); data_ok = 1'($urandom_range(0, 1)); rdata = $urandom;
        #1;
        chk("gap_stall", 32'(cpu_stall), 32'd0);
        chk("gap_req", 32'(req), 32'd0);
        @(negedge clk);
        addr_ok = 1'b0; data_ok = 1'b0;
        #1;
        chk("gap_req2", 32'(req), 32'd0);
        chk("gap_rdata", cpu_rdata, exp_rdata);
    endtask

    // Run an access whose attributes come from the reference model.
    task automatic run_model(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                             input int wa, input int wdl, input logic [31:0] rd, input int hold);
        logic [3:0]  dec;
        logic [31:0] ma;
        dec = m_dec(wen, a[1:0]);
        ma  = m_map(a);
        run_txn(wen, a, wd, dec[3:2], {ma[31:2], dec[1:0]}, wa, wdl, rd, hold);
    endtask

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] a;
        logic [1:0]  size;
        logic [1:0]  off;
    } vec_t;

    vec_t vecs[10];
    logic [31:0] ma;

    initial begin
        vecs[0] = '{4'b0001, 32'h0000_1003, 2'd0, 2'd0};
        vecs[1] = '{4'b0010, 32'h0000_2000, 2'd1 - 2'd1, 2'd1};
        vecs[2] = '{4'b0100, 32'h8000_0011, 2'd0, 2'd2};
        vecs[3] = '{4'b1000, 32'hA000_0100, 2'd0, 2'd3};
        vecs[4] = '{4'b0011, 32'h0040_0002, 2'd1, 2'd0};
        vecs[5] = '{4'b1100, 32'h9000_0000, 2'd1, 2'd2};
        vecs[6] = '{4'b1111, 32'h0000_3002, 2'd2, 2'd2};
        vecs[7] = '{4'b0000, 32'hBFC0_0001, 2'd2, 2'd1};
        vecs[8] = '{4'b0110, 32'h0000_4003, 2'd2, 2'd3};
        vecs[9] = '{4'b1010, 32'hC000_0000, 2'd2, 2'd0};

        resetn = 1'b0; cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        cpu_longest_stall = 1'b0; rdata = 32'h0; addr_ok = 1'b0; data_ok = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_size", 32'(size), 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_stall_follows_en", 32'(cpu_stall), 32'd1);
        @(negedge clk);
        cpu_en = 1'b0; resetn = 1'b1;
        #1;
        chk("rst_stall_low", 32'(cpu_stall), 32'd0);

        // Word read at boot vector, addr_ok after 2 ADDR cycles, data_ok 3 later
        ma = m_map(32'hBFC0_0000);
`ifdef SRAM_LIKE_BRIDGE_ADDR_MAP_EN
        chk("map_boot", ma, 32'h1FC0_0000);
`else
        chk("map_boot", ma, 32'hBFC0_0000);
`endif
        run_txn(4'b0000, 32'hBFC0_0000, 32'h0, 2'd2, ma, 1, 3, 32'h1234_5678, 0);
        chk("boot_rdata", cpu_rdata, 32'h1234_5678);

        // Decode table, minimum latency
        for (int i = 0; i < 10; i++) begin
            ma = m_map(vecs[i].a);
            run_txn(vecs[i].wen, vecs[i].a, $urandom, vecs[i].size, {ma[31:2], vecs[i].off},
                    0, 0, $urandom, 0);
        end

        // Read completes while the pipeline stays stalled 4 more cycles
        run_txn(4'b0000, 32'h0000_8000, 32'h0, 2'd2, 32'h0000_8000, 0, 1, 32'hCAFE_F00D, 4);

        // Reset pulsed during DATA, late data_ok then dropped
        @(negedge clk);
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_1000; cpu_longest_stall = 1'b1;
        @(negedge clk);
        addr_ok = 1'b1; data_ok = 1'b0;
        @(negedge clk);
        addr_ok = 1'b0;
        #1;
        chk("rstmid_data_req", 32'(req), 32'd0);
        chk("rstmid_data_stall", 32'(cpu_stall), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("rstmid_req", 32'(req), 32'd0);
        chk("rstmid_wr", 32'(wr), 32'd0);
        chk("rstmid_addr", addr, 32'h0);
        chk("rstmid_rdata", cpu_rdata, 32'h0);
        exp_rdata = 32'h0;
        @(negedge clk);
        resetn = 1'b1; cpu_en = 1'b0; cpu_longest_stall = 1'b0; data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        data_ok = 1'b0;
        #1;
        chk("late_dok_rdata", cpu_rdata, 32'h0);
        chk("late_dok_req", 32'(req), 32'd0);
        chk("late_dok_stall", 32'(cpu_stall), 32'd0);
        run_model(4'b1111, 32'h0000_2004, 32'h5555_AAAA, 0, 0, 32'h0, 0);

        // Random accesses against the model
        for (int n = 0; n < 60; n++) begin
            logic [3:0] w;
            case ($urandom_range(0, 3))
                0: w = 4'b0000;
                1: w = 4'(1 << $urandom_range(0, 3));
                2: w = ($urandom_range(0, 1) != 0) ? 4'b0011 : 4'b1100;
                default: w = 4'($urandom);
            endcase
            run_model(w, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
